// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register with sticky halt; optional FETCH_PERF_CNT_EN fetch counter.
// Latency: one cycle from PCF to InstrD; redirect lands on PCF the next cycle.
// Backpressure: StallF/StallD hold PC and IF/ID; FlushD/PCSrcE bubble D; halt freezes fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        DoneD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        HaltF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCountD
`endif
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} halt_state_t;

    halt_state_t state_q, state_d;

    logic [31:0] PCPlus4F;
    logic [31:0] PCNextF;
    logic        pc_load;
    logic        bubble_d;
    logic        fetch_load;

    assign PCPlus4F = PCF + 32'd4;
    assign PCNextF  = PCSrcE ? PCTargetE : PCPlus4F;

    // A redirect always wins, even over a halted or stalled fetch.
    assign pc_load    = PCSrcE | ~(HaltF | StallF);
    assign bubble_d   = FlushD | PCSrcE;
    assign fetch_load = ~bubble_d & ~StallD & ~HaltF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else if (pc_load) begin
            PCF <= PCNextF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= RESET_PC;
            PCPlus4D <= RESET_PC + 32'd4;
        end else if (bubble_d) begin
            InstrD   <= NOP_INSTR;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end else if (StallD) begin
            InstrD   <= InstrD;
        end else if (HaltF) begin
            InstrD   <= NOP_INSTR;
        end else begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a committed, non-stalled copy of the instruction in D may halt fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (DoneD & ~PCSrcE & ~FlushD & ~StallD) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        HaltF = (state_q == HALTED);
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FetchCountD <= 32'd0;
        end else if (fetch_load) begin
            FetchCountD <= FetchCountD + 32'd1;
        end
    end
`else
    logic unused_fetch_load;
    assign unused_fetch_load = fetch_load;
`endif

endmodule
